// File: rtl/maquina_escritura.sv
// RTC write sequencer: snapshots time/date bytes on a start request and walks the
// shared bus through address/data phases, ending with a RAM-to-clock/timer transfer.
module maquina_escritura #(
  parameter logic [7:0] A_SEG_C  = 8'h21,
  parameter logic [7:0] A_MIN_C  = 8'h22,
  parameter logic [7:0] A_HORA_C = 8'h23,
  parameter logic [7:0] A_SEG_T  = 8'h41,
  parameter logic [7:0] A_MIN_T  = 8'h42,
  parameter logic [7:0] A_HORA_T = 8'h43,
  parameter logic [7:0] A_DIA    = 8'h24,
  parameter logic [7:0] A_MES    = 8'h25,
  parameter logic [7:0] A_ANO    = 8'h26,
  parameter logic [7:0] CMD_TR_C = 8'hF1,
  parameter logic [7:0] CMD_TR_T = 8'hF2,
  parameter logic [7:0] CMD_DATO = 8'h01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Escritura,
  input  logic       En_clk,
  input  logic       DIR,
  input  logic       DAT,
  input  logic       cambio_estado,
  input  logic [7:0] Seg_E,
  input  logic [7:0] Min_E,
  input  logic [7:0] Hora_E,
  input  logic [7:0] Dia_E,
  input  logic [7:0] Mes_E,
  input  logic [7:0] Ano_E,
  output logic [7:0] Dir_E,
  output logic       E_Esc,
  output logic       Tr_Esc,
  output logic       Term_Esc
);

  typedef enum logic [2:0] {
    IDLE, W_SEG, W_MIN, W_HORA, W_DIA, W_MES, W_ANO, W_TR
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] dir_reg, dir_next;
  logic       e_esc_reg, e_esc_next;
  logic       tr_esc_reg, tr_esc_next;
  logic       term_reg, term_next;
  logic       mode_reg, mode_next;
  logic [7:0] seg_reg, min_reg, hora_reg, dia_reg, mes_reg, ano_reg;
  logic [7:0] seg_next, min_next, hora_next, dia_next, mes_next, ano_next;
  logic [7:0] state_addr, state_data;
  state_t     state_after;

  // Address, captured data and successor for the current write state.
  always_comb begin
    state_addr  = 8'hFF;
    state_data  = 8'hFF;
    state_after = IDLE;
    case (state_reg)
      W_SEG:   begin state_addr = mode_reg ? A_SEG_C  : A_SEG_T;  state_data = seg_reg;  state_after = W_MIN;  end
      W_MIN:   begin state_addr = mode_reg ? A_MIN_C  : A_MIN_T;  state_data = min_reg;  state_after = W_HORA; end
      W_HORA:  begin state_addr = mode_reg ? A_HORA_C : A_HORA_T; state_data = hora_reg;
                     state_after = mode_reg ? W_DIA : W_TR; end
      W_DIA:   begin state_addr = A_DIA; state_data = dia_reg; state_after = W_MES; end
      W_MES:   begin state_addr = A_MES; state_data = mes_reg; state_after = W_ANO; end
      W_ANO:   begin state_addr = A_ANO; state_data = ano_reg; state_after = W_TR;  end
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    dir_next    = dir_reg;
    e_esc_next  = e_esc_reg;
    tr_esc_next = tr_esc_reg;
    term_next   = 1'b0;
    mode_next   = mode_reg;
    seg_next    = seg_reg;
    min_next    = min_reg;
    hora_next   = hora_reg;
    dia_next    = dia_reg;
    mes_next    = mes_reg;
    ano_next    = ano_reg;
    case (state_reg)
      IDLE: begin
        dir_next = 8'hFF;
        if (Escritura) begin
          seg_next   = Seg_E;
          min_next   = Min_E;
          hora_next  = Hora_E;
          dia_next   = Dia_E;
          mes_next   = Mes_E;
          ano_next   = Ano_E;
          mode_next  = En_clk;
          state_next = W_SEG;
          e_esc_next = 1'b1;
        end
      end
      W_TR: begin
        if (DIR) begin
          dir_next = mode_reg ? CMD_TR_C : CMD_TR_T;
        end else if (DAT) begin
          dir_next    = CMD_DATO;
          tr_esc_next = 1'b1;
        end else if (cambio_estado) begin
          state_next  = IDLE;
          e_esc_next  = 1'b0;
          tr_esc_next = 1'b0;
          term_next   = 1'b1;
          dir_next    = 8'hFF;
        end
      end
      default: begin
        if (DIR)                dir_next   = state_addr;
        else if (DAT)           dir_next   = state_data;
        else if (cambio_estado) state_next = state_after;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      dir_reg    <= 8'hFF;
      e_esc_reg  <= 1'b0;
      tr_esc_reg <= 1'b0;
      term_reg   <= 1'b0;
      mode_reg   <= 1'b0;
      seg_reg    <= 8'h00;
      min_reg    <= 8'h00;
      hora_reg   <= 8'h00;
      dia_reg    <= 8'h00;
      mes_reg    <= 8'h00;
      ano_reg    <= 8'h00;
    end else begin
      state_reg  <= state_next;
      dir_reg    <= dir_next;
      e_esc_reg  <= e_esc_next;
      tr_esc_reg <= tr_esc_next;
      term_reg   <= term_next;
      mode_reg   <= mode_next;
      seg_reg    <= seg_next;
      min_reg    <= min_next;
      hora_reg   <= hora_next;
      dia_reg    <= dia_next;
      mes_reg    <= mes_next;
      ano_reg    <= ano_next;
    end
  end

  assign Dir_E    = dir_reg;
  assign E_Esc    = e_esc_reg;
  assign Tr_Esc   = tr_esc_reg;
  assign Term_Esc = term_reg;

endmodule

// File: tb/tb_maquina_escritura.sv
// Directed, table-driven bench for the RTC write sequencer.
module tb_maquina_escritura;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Escritura = 1'b0, En_clk = 1'b0;
  logic       DIR = 1'b0, DAT = 1'b0, cambio_estado = 1'b0;
  logic [7:0] Seg_E = 8'h00, Min_E = 8'h00, Hora_E = 8'h00;
  logic [7:0] Dia_E = 8'h00, Mes_E = 8'h00, Ano_E = 8'h00;
  logic [7:0] Dir_E;
  logic       E_Esc, Tr_Esc, Term_Esc;

  int n_cmp = 0;
  int n_bad = 0;

  maquina_escritura dut (
    .clk(clk), .reset(reset), .Escritura(Escritura), .En_clk(En_clk),
    .DIR(DIR), .DAT(DAT), .cambio_estado(cambio_estado),
    .Seg_E(Seg_E), .Min_E(Min_E), .Hora_E(Hora_E),
    .Dia_E(Dia_E), .Mes_E(Mes_E), .Ano_E(Ano_E),
    .Dir_E(Dir_E), .E_Esc(E_Esc), .Tr_Esc(Tr_Esc), .Term_Esc(Term_Esc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, esc, dir, dat, ce;
    logic [7:0] exp_dir;
    logic       exp_e, exp_tr, exp_term;
  } vec_t;

  vec_t vq[$];

  task automatic push(input logic rst, esc, dir, dat, ce,
                      input logic [7:0] edir, input logic ee, etr, eterm);
    vec_t v;
    v.rst = rst; v.esc = esc; v.dir = dir; v.dat = dat; v.ce = ce;
    v.exp_dir = edir; v.exp_e = ee; v.exp_tr = etr; v.exp_term = eterm;
    vq.push_back(v);
  endtask

  task automatic push_start();
    push(0, 1, 0, 0, 0, 8'hFF, 1, 0, 0);
  endtask

  task automatic push_idle();
    push(0, 0, 0, 0, 0, 8'hFF, 0, 0, 0);
  endtask

  // One write state: DIR -> address, DAT -> data, cambio_estado -> data held.
  task automatic push_state(input logic esc, input logic [7:0] addr, input logic [7:0] data);
    push(0, esc, 1, 0, 0, addr, 1, 0, 0);
    push(0, esc, 0, 1, 0, data, 1, 0, 0);
    push(0, esc, 0, 0, 1, data, 1, 0, 0);
  endtask

  task automatic push_tr(input logic esc, input logic [7:0] cmd);
    push(0, esc, 1, 0, 0, cmd,   1, 0, 0);
    push(0, esc, 0, 1, 0, 8'h01, 1, 1, 0);
    push(0, esc, 0, 0, 1, 8'hFF, 0, 0, 1);
  endtask

  task automatic run_q(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = vq[i].rst; Escritura = vq[i].esc;
      DIR = vq[i].dir; DAT = vq[i].dat; cambio_estado = vq[i].ce;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({Dir_E, E_Esc, Tr_Esc, Term_Esc} !==
          {vq[i].exp_dir, vq[i].exp_e, vq[i].exp_tr, vq[i].exp_term}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got Dir_E=%h E=%b Tr=%b Term=%b, want Dir_E=%h E=%b Tr=%b Term=%b",
                 name, i, Dir_E, E_Esc, Tr_Esc, Term_Esc,
                 vq[i].exp_dir, vq[i].exp_e, vq[i].exp_tr, vq[i].exp_term);
      end else begin
        $display("ok   %s[%0d]: Dir_E=%h E=%b Tr=%b Term=%b",
                 name, i, Dir_E, E_Esc, Tr_Esc, Term_Esc);
      end
    end
    vq.delete();
    @(negedge clk);
    reset = 1'b0; Escritura = 1'b0; DIR = 1'b0; DAT = 1'b0; cambio_estado = 1'b0;
  endtask

  task automatic set_clock_vals();
    En_clk = 1'b1;
    Seg_E = 8'h45; Min_E = 8'h30; Hora_E = 8'h12;
    Dia_E = 8'h15; Mes_E = 8'h09; Ano_E = 8'h16;
  endtask

  initial begin
    // Reset, idle, and strobes ignored in IDLE.
    push(1, 0, 0, 0, 0, 8'hFF, 0, 0, 0);
    push(1, 0, 0, 0, 0, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 5; i++) push_idle();
    push(0, 0, 1, 1, 1, 8'hFF, 0, 0, 0);
    run_q("reset_idle");

    // Full clock-mode sequence.
    set_clock_vals();
    push_start();
    push_state(0, 8'h21, 8'h45);
    push_state(0, 8'h22, 8'h30);
    push_state(0, 8'h23, 8'h12);
    push_state(0, 8'h24, 8'h15);
    push_state(0, 8'h25, 8'h09);
    push_state(0, 8'h26, 8'h16);
    push_tr(0, 8'hF1);
    push_idle();
    run_q("clock");

    // Timer mode: day/month/year skipped.
    En_clk = 1'b0;
    Seg_E = 8'h10; Min_E = 8'h05; Hora_E = 8'h01;
    push_start();
    push_state(0, 8'h41, 8'h10);
    push_state(0, 8'h42, 8'h05);
    push_state(0, 8'h43, 8'h01);
    push_tr(0, 8'hF2);
    push_idle();
    run_q("timer");

    // Inputs changed and Escritura pulsed mid-sequence are ignored.
    set_clock_vals();
    push_start();
    run_q("ign_start");
    Seg_E = 8'h99; En_clk = 1'b0; Dia_E = 8'h77;
    push_state(0, 8'h21, 8'h45);
    push_state(1, 8'h22, 8'h30);
    push_state(0, 8'h23, 8'h12);
    push_state(0, 8'h24, 8'h15);
    push_state(0, 8'h25, 8'h09);
    push_state(0, 8'h26, 8'h16);
    push_tr(0, 8'hF1);
    push_idle();
    run_q("ignore");

    // Reset in W_MES after its DIR aborts without Term_Esc; restart is clean.
    set_clock_vals();
    push_start();
    push_state(0, 8'h21, 8'h45);
    push_state(0, 8'h22, 8'h30);
    push_state(0, 8'h23, 8'h12);
    push_state(0, 8'h24, 8'h15);
    push(0, 0, 1, 0, 0, 8'h25, 1, 0, 0);
    push(1, 0, 0, 0, 0, 8'hFF, 0, 0, 0);
    push_idle();
    push(0, 0, 0, 0, 1, 8'hFF, 0, 0, 0);
    push_start();
    push_state(0, 8'h21, 8'h45);
    push_state(0, 8'h22, 8'h30);
    push_state(0, 8'h23, 8'h12);
    push_state(0, 8'h24, 8'h15);
    push_state(0, 8'h25, 8'h09);
    push_state(0, 8'h26, 8'h16);
    push_tr(0, 8'hF1);
    push_idle();
    run_q("abort");

    // DIR+cambio_estado in W_HORA loads the address and stays; DAT then gives hour data.
    // Escritura held through Term_Esc restarts immediately.
    set_clock_vals();
    push_start();
    push_state(1, 8'h21, 8'h45);
    push_state(1, 8'h22, 8'h30);
    push(0, 1, 1, 0, 1, 8'h23, 1, 0, 0);
    push(0, 1, 0, 1, 0, 8'h12, 1, 0, 0);
    push(0, 1, 0, 0, 1, 8'h12, 1, 0, 0);
    push_state(1, 8'h24, 8'h15);
    push_state(1, 8'h25, 8'h09);
    push_state(1, 8'h26, 8'h16);
    push_tr(1, 8'hF1);
    push_start();
    push(0, 0, 1, 0, 0, 8'h21, 1, 0, 0);
    push(0, 0, 0, 1, 0, 8'h45, 1, 0, 0);
    push(1, 0, 0, 0, 0, 8'hFF, 0, 0, 0);
    run_q("prio_b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
